// File: rtl/timer_scheduler_pkg.sv
// Shared types and helpers for the timer scheduler: FSM state encoding,
// default counter width and index-width calculation.
package timer_pkg;

    typedef enum logic {IDLE, SCAN} sched_state_t;

    localparam int DEFAULT_CNT_W = 16;

    // Channel index width; a single channel still needs a 1-bit index
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timer_scheduler_if.sv
// Control/status bundle between the bus register block and the timer
// scheduler; the register block is the master, the scheduler the slave.
interface timer_scheduler_if
    import timer_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = DEFAULT_CNT_W
);

    logic [N_CH-1:0]            start;
    logic [N_CH-1:0]            stop;
    logic [N_CH-1:0]            periodic;
    logic [N_CH-1:0][CNT_W-1:0] load_val;
    logic [N_CH-1:0]            busy;
    logic [N_CH-1:0]            expire;
    logic                       tick;

    modport master (
        output start, stop, periodic, load_val,
        input  busy, expire, tick
    );

    modport slave (
        input  start, stop, periodic, load_val,
        output busy, expire, tick
    );

endinterface

// File: rtl/timer_scheduler_tick_gen.sv
// Tick prescaler: counts 0..PRESCALE-1, registers a one-cycle tick on each
// wrap and exposes the wrap condition so the scheduler can start its scan
// in the same cycle the tick is visible.
module tick_gen #(
    parameter int PRESCALE = 5000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic wrap
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    assign wrap = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= wrap;
            count <= wrap ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/timer_scheduler.sv
// N_CH timeout channels sharing one prescaler and one decrementer; after
// each tick the channels are visited round-robin, one per clock.
module timer_scheduler
    import timer_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int PRESCALE = 5000000,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    timer_scheduler_if.slave bus
);

    localparam int               IDX_W    = idx_width(N_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    // A scan must finish before the next tick, otherwise slots would be skipped
    generate
        if (PRESCALE < N_CH + 2) begin : g_prescale_check
            $error("timer_scheduler: PRESCALE must be >= N_CH+2");
        end
    endgenerate

    logic wrap;
    logic tick;

    tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .wrap (wrap)
    );

    sched_state_t     state;
    logic [IDX_W-1:0] idx;

    logic [N_CH-1:0]  busy;
    logic [N_CH-1:0]  periodic_q;
    logic [N_CH-1:0]  expire;
    logic [CNT_W-1:0] remaining [N_CH];
    logic [CNT_W-1:0] reload    [N_CH];

    logic [CNT_W-1:0] cur_rem;
    logic [CNT_W-1:0] dec_rem;
    logic             cur_is_one;

    assign cur_rem    = remaining[idx];
    assign dec_rem    = cur_rem - CNT_W'(1);
    assign cur_is_one = (cur_rem == CNT_W'(1));

    // Entering SCAN on the wrap edge makes state==SCAN, idx==0 coincide with tick=1
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wrap) begin
                        state <= SCAN;
                        idx   <= '0;
                    end
                end
                SCAN: begin
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Per-channel update, priority stop > start > scan; a zero-length start is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            periodic_q <= '0;
            expire     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                remaining[i] <= '0;
                reload[i]    <= '0;
            end
        end else begin
            expire <= '0;
            for (int i = 0; i < N_CH; i++) begin
                if (bus.stop[i]) begin
                    busy[i] <= 1'b0;
                end else if (bus.start[i] && (bus.load_val[i] != '0)) begin
                    busy[i]       <= 1'b1;
                    periodic_q[i] <= bus.periodic[i];
                    remaining[i]  <= bus.load_val[i];
                    reload[i]     <= bus.load_val[i];
                end else if ((state == SCAN) && (idx == IDX_W'(i)) && busy[i]) begin
                    if (cur_is_one) begin
                        expire[i] <= 1'b1;
                        if (periodic_q[i]) begin
                            remaining[i] <= reload[i];
                        end else begin
                            busy[i] <= 1'b0;
                        end
                    end else begin
                        remaining[i] <= dec_rem;
                    end
                end
            end
        end
    end

    assign bus.busy   = busy;
    assign bus.expire = expire;
    assign bus.tick   = tick;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler (N_CH=4, PRESCALE=8, CNT_W=8): a table
// of per-edge vectors with hand-computed outputs plus a periodic/stop sequence.
module tb_timer_scheduler;

    localparam int N_CH     = 4;
    localparam int PRESCALE = 8;
    localparam int CNT_W    = 8;

    logic clk;
    logic rst;

    timer_scheduler_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    timer_scheduler #(
        .N_CH     (N_CH),
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          edge_no;
        logic        rst;
        logic [3:0]  start;
        logic [3:0]  stop;
        logic [3:0]  periodic;
        logic [31:0] load_val;
        logic [3:0]  exp_busy;
        logic [3:0]  exp_expire;
        logic        exp_tick;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   errors   = 0;
    int   edge_cnt = 0;

    function automatic vec_t mk(input int e, input logic r, input logic [3:0] st,
                                input logic [3:0] sp, input logic [3:0] per,
                                input logic [31:0] lv, input logic [3:0] b,
                                input logic [3:0] ex, input logic t);
        vec_t v;
        v.edge_no    = e;
        v.rst        = r;
        v.start      = st;
        v.stop       = sp;
        v.periodic   = per;
        v.load_val   = lv;
        v.exp_busy   = b;
        v.exp_expire = ex;
        v.exp_tick   = t;
        return v;
    endfunction

    // Drive one cycle of inputs at the falling edge, sample 1 time unit after the rising edge
    task automatic stepCycle(input logic r, input logic [3:0] st, input logic [3:0] sp,
                             input logic [3:0] per, input logic [31:0] lv);
        @(negedge clk);
        rst          = r;
        bus.start    = st;
        bus.stop     = sp;
        bus.periodic = per;
        bus.load_val = lv;
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", name, edge_cnt, got, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] eb,
                               input logic [3:0] ee, input logic et);
        checks++;
        if (bus.busy !== eb) begin
            errors++;
            $display("[TB] FAIL %s busy at edge %0d: got %b expected %b", name, edge_cnt, bus.busy, eb);
        end
        checks++;
        if (bus.expire !== ee) begin
            errors++;
            $display("[TB] FAIL %s expire at edge %0d: got %b expected %b", name, edge_cnt, bus.expire, ee);
        end
        checks++;
        if (bus.tick !== et) begin
            errors++;
            $display("[TB] FAIL %s tick at edge %0d: got %b expected %b", name, edge_cnt, bus.tick, et);
        end
    endtask

    // Idle up to the edge before the vector, then apply it on its own edge and compare
    task automatic applyStimulus(input vec_t v, input int row);
        while (edge_cnt < v.edge_no - 1) stepCycle(1'b0, '0, '0, '0, '0);
        stepCycle(v.rst, v.start, v.stop, v.periodic, v.load_val);
        checkOutput($sformatf("row%0d", row), v.exp_busy, v.exp_expire, v.exp_tick);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int first_exp;
        int second_exp;
        int hits;

        rst          = 1'b1;
        bus.start    = '0;
        bus.stop     = '0;
        bus.periodic = '0;
        bus.load_val = '0;

        //         edge rst start    stop     per      load_val      busy     expire   tick
        vecs.push_back(mk(  1, 0, 4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0001, 4'b0000, 0));
        vecs.push_back(mk(  2, 0, 4'b0100, 4'b0000, 4'b0100, 32'h00020000, 4'b0101, 4'b0000, 0));
        vecs.push_back(mk(  3, 0, 4'b0010, 4'b0000, 4'b0000, 32'h00000900, 4'b0111, 4'b0000, 0));
        vecs.push_back(mk(  7, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0111, 4'b0000, 0));
        vecs.push_back(mk(  8, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0111, 4'b0000, 1));
        vecs.push_back(mk(  9, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0111, 4'b0000, 0));
        vecs.push_back(mk( 16, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0111, 4'b0000, 1));
        vecs.push_back(mk( 19, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0111, 4'b0100, 0));
        vecs.push_back(mk( 24, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0111, 4'b0000, 1));
        vecs.push_back(mk( 25, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0110, 4'b0001, 0));
        vecs.push_back(mk( 26, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0110, 4'b0000, 0));
        vecs.push_back(mk( 34, 0, 4'b0010, 4'b0000, 4'b0000, 32'h00000500, 4'b0110, 4'b0000, 0));
        vecs.push_back(mk( 35, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0110, 4'b0100, 0));
        vecs.push_back(mk( 40, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0110, 4'b0000, 1));
        vecs.push_back(mk( 51, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0110, 4'b0100, 0));
        vecs.push_back(mk( 66, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0110, 4'b0000, 0));
        vecs.push_back(mk( 67, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0110, 4'b0100, 0));
        vecs.push_back(mk( 74, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0100, 4'b0010, 0));
        vecs.push_back(mk( 75, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0100, 4'b0000, 0));
        vecs.push_back(mk( 76, 0, 4'b1000, 4'b1000, 4'b0000, 32'h04000000, 4'b0100, 4'b0000, 0));
        vecs.push_back(mk( 77, 0, 4'b1000, 4'b0000, 4'b0000, 32'h00000000, 4'b0100, 4'b0000, 0));
        vecs.push_back(mk( 83, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0100, 4'b0100, 0));
        vecs.push_back(mk( 85, 0, 4'b1000, 4'b0000, 4'b0000, 32'h01000000, 4'b1100, 4'b0000, 0));
        vecs.push_back(mk( 88, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b1100, 4'b0000, 1));
        vecs.push_back(mk( 91, 1, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk( 92, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk( 98, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk( 99, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 1));
        vecs.push_back(mk(103, 0, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 0));

        $display("[TB] reset for 2 cycles");
        stepCycle(1'b1, '0, '0, '0, '0);
        checkOutput("reset1", 4'b0000, 4'b0000, 1'b0);
        stepCycle(1'b1, '0, '0, '0, '0);
        checkOutput("reset2", 4'b0000, 4'b0000, 1'b0);
        edge_cnt = 0;

        $display("[TB] applying %0d table vectors", vecs.size());
        foreach (vecs[r]) applyStimulus(vecs[r], r);

        // Periodic one-tick channel: expires once per tick window, then stop silences it
        $display("[TB] periodic ch0 with load 1, then stop");
        stepCycle(1'b0, 4'b0001, 4'b0000, 4'b0001, 32'h00000001);
        checkOutput("per_arm", 4'b0001, 4'b0000, 1'b0);

        first_exp = -1;
        for (int k = 0; k < 20 && first_exp < 0; k++) begin
            stepCycle(1'b0, '0, '0, '0, '0);
            if (bus.expire[0]) first_exp = edge_cnt;
        end
        checkValue("per_first_edge", first_exp, 108);

        second_exp = -1;
        for (int k = 0; k < 20 && second_exp < 0; k++) begin
            stepCycle(1'b0, '0, '0, '0, '0);
            if (bus.expire[0]) second_exp = edge_cnt;
        end
        checkValue("per_spacing", second_exp - first_exp, PRESCALE);
        checkValue("per_busy_held", int'(bus.busy), 1);

        stepCycle(1'b0, 4'b0000, 4'b0001, 4'b0000, 32'h00000000);
        checkOutput("stop_ch0", 4'b0000, 4'b0000, 1'b0);

        hits = 0;
        for (int k = 0; k < 2 * PRESCALE; k++) begin
            stepCycle(1'b0, '0, '0, '0, '0);
            if (bus.expire != '0) hits++;
        end
        checkValue("stopped_no_expire", hits, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
